mci_mcu_sram_ecc_wb: RTL and testbench

- Sits between the MCU SRAM controller's memory-request port and the physical MCU SRAM.
- Passes functional requests through with zero latency.
- Watches read data phases for correctable (single-bit) ECC errors, queues the corrected word, and writes it back to the SRAM in idle cycles.
- Keeps saturating SEC/DED/drop counters for MCI status registers.

---
 rtl/mci_mcu_sram_ecc_wb.sv | 154 +++++++++++++++
 tb/tb_mci_mcu_sram_ecc_wb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mci_mcu_sram_ecc_wb.sv
// rtl/mci_mcu_sram_ecc_wb.sv - MCU SRAM single-bit ECC scrub write-back with error counters
module mci_mcu_sram_ecc_wb #(
  parameter int MCU_SRAM_ADDR_W = 18,
  parameter int WB_DEPTH        = 2,
  parameter int DW              = 39
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_en,
  input  logic                       ctrl_cs,
  input  logic                       ctrl_we,
  input  logic [MCU_SRAM_ADDR_W-1:0] ctrl_addr,
  input  logic [DW-1:0]              ctrl_wdata,
  output logic [DW-1:0]              ctrl_rdata,
  input  logic [31:0]                rd_corr_data,
  input  logic                       single_ecc_error,
  input  logic                       double_ecc_error,
  output logic                       sram_cs,
  output logic                       sram_we,
  output logic [MCU_SRAM_ADDR_W-1:0] sram_addr,
  output logic [DW-1:0]              sram_wdata,
  input  logic [DW-1:0]              sram_rdata,
  output logic                       wb_pending,
  output logic                       wb_done,
  output logic [15:0]                sec_count,
  output logic [15:0]                ded_count,
  output logic [15:0]                wb_drop_count
);

  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CW = $clog2(WB_DEPTH + 1);

  // Hamming SECDED check bits for a 32-bit word; bit 6 is overall parity.
  function automatic logic [6:0] rvecc_encode(input logic [31:0] d);
    logic [6:0] e;
    e[0] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[11]^d[13]^d[15]^d[17]^d[19]^d[21]^d[23]^d[25]^d[26]^d[28]^d[30];
    e[1] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[10]^d[12]^d[13]^d[16]^d[17]^d[20]^d[21]^d[24]^d[25]^d[27]^d[28]^d[31];
    e[2] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[10]^d[14]^d[15]^d[16]^d[17]^d[22]^d[23]^d[24]^d[25]^d[29]^d[30]^d[31];
    e[3] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[10]^d[18]^d[19]^d[20]^d[21]^d[22]^d[23]^d[24]^d[25];
    e[4] = d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[20]^d[21]^d[22]^d[23]^d[24]^d[25];
    e[5] = d[26]^d[27]^d[28]^d[29]^d[30]^d[31];
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [MCU_SRAM_ADDR_W-1:0] q_addr [WB_DEPTH];
  logic [31:0]                q_data [WB_DEPTH];
  logic [WB_DEPTH-1:0]        q_valid;
  logic [PW-1:0]              head_q, tail_q;
  logic [CW-1:0]              count_q;
  logic                       rd_pend_q;
  logic [MCU_SRAM_ADDR_W-1:0] rd_addr_q;
  logic [15:0]                sec_q, ded_q, drop_q;

  logic ctrl_wr, not_empty, full, head_valid, pop, issue;
  logic dup, want_push, push, drop, sec_hit, ded_hit;

  assign ctrl_wr    = ctrl_cs & ctrl_we;
  assign not_empty  = (count_q != '0);
  assign full       = (count_q == CW'(WB_DEPTH));
  assign head_valid = q_valid[head_q];
  // Stale (invalidated) heads are discarded even while the controller is busy.
  assign pop        = not_empty & (~head_valid | ~ctrl_cs);
  // No write-back may leave in the reset cycle.
  assign issue      = not_empty & head_valid & ~ctrl_cs & ~rst;

  assign sec_hit    = rd_pend_q & single_ecc_error & ~double_ecc_error;
  assign ded_hit    = rd_pend_q & double_ecc_error;
  assign want_push  = sec_hit & wb_en & ~dup & ~(ctrl_wr & (ctrl_addr == rd_addr_q));
  assign push       = want_push & (~full | pop);
  assign drop       = want_push & full & ~pop;

  assign ctrl_rdata    = sram_rdata;
  assign wb_pending    = |q_valid;
  assign wb_done       = issue;
  assign sec_count     = sec_q;
  assign ded_count     = ded_q;
  assign wb_drop_count = drop_q;

  // Dedup: the faulting address already sits in a live queue entry.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (q_valid[i] && (q_addr[i] == rd_addr_q)) dup = 1'b1;
    end
  end

  // SRAM port mux: functional traffic first, then the queue head, else idle.
  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (ctrl_cs) begin
      sram_cs    = 1'b1;
      sram_we    = ctrl_we;
      sram_addr  = ctrl_addr;
      sram_wdata = ctrl_wdata;
    end else if (issue) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = q_addr[head_q];
      sram_wdata = {rvecc_encode(q_data[head_q]), q_data[head_q]};
    end
  end

  // Read tracking and write-back queue; push is applied after pop/invalidate so it wins on a shared slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      q_valid   <= '0;
    end else begin
      rd_pend_q <= ctrl_cs & ~ctrl_we;
      if (ctrl_cs && !ctrl_we) rd_addr_q <= ctrl_addr;
      for (int i = 0; i < WB_DEPTH; i++) begin
        if (ctrl_wr && (q_addr[i] == ctrl_addr)) q_valid[i] <= 1'b0;
      end
      if (pop) begin
        q_valid[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
      end
      if (push) begin
        q_valid[tail_q] <= 1'b1;
        q_addr[tail_q]  <= rd_addr_q;
        q_data[tail_q]  <= rd_corr_data;
        tail_q          <= ptr_inc(tail_q);
      end
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Saturating status counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q  <= '0;
      ded_q  <= '0;
      drop_q <= '0;
    end else begin
      if (sec_hit && (sec_q != 16'hFFFF))  sec_q  <= sec_q + 16'd1;
      if (ded_hit && (ded_q != 16'hFFFF))  ded_q  <= ded_q + 16'd1;
      if (drop && (drop_q != 16'hFFFF))    drop_q <= drop_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_mci_mcu_sram_ecc_wb.sv
// tb/tb_mci_mcu_sram_ecc_wb.sv - directed bench for mci_mcu_sram_ecc_wb
module tb_mci_mcu_sram_ecc_wb;

  localparam int AW = 18;
  localparam int DW = 39;

  // Clean SRAM words {ecc, data} for the data values used below.
  localparam logic [DW-1:0] W_0001 = 39'h43_0000_0001;
  localparam logic [DW-1:0] W_0010 = 39'h49_0000_0010;
  localparam logic [DW-1:0] W_8000 = 39'h26_8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_en;
  logic          ctrl_cs, ctrl_we;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_wdata, ctrl_rdata;
  logic [31:0]   rd_corr_data;
  logic          single_ecc_error, double_ecc_error;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic          wb_pending, wb_done;
  logic [15:0]   sec_count, ded_count, wb_drop_count;

  int checks = 0;
  int errors = 0;

  mci_mcu_sram_ecc_wb #(.MCU_SRAM_ADDR_W(AW), .WB_DEPTH(2), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en),
    .ctrl_cs(ctrl_cs), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr),
    .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata),
    .rd_corr_data(rd_corr_data), .single_ecc_error(single_ecc_error),
    .double_ecc_error(double_ecc_error),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .wb_pending(wb_pending), .wb_done(wb_done),
    .sec_count(sec_count), .ded_count(ded_count), .wb_drop_count(wb_drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, land 1ns after the edge, and return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    ctrl_cs = 1'b0; ctrl_we = 1'b0; ctrl_addr = '0; ctrl_wdata = '0;
    rd_corr_data = '0; single_ecc_error = 1'b0; double_ecc_error = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    ctrl_cs = 1'b1; ctrl_we = 1'b0; ctrl_addr = a;
  endtask

  task automatic sec(input logic [31:0] d);
    single_ecc_error = 1'b1; rd_corr_data = d;
  endtask

  initial begin
    rst = 1'b1; wb_en = 1'b1; sram_rdata = '0;
    tick(); tick(); tick();
    #1;
    chk("rst_sec", sec_count, 0);
    chk("rst_ded", ded_count, 0);
    chk("rst_drop", wb_drop_count, 0);
    chk("rst_pending", wb_pending, 0);
    chk("rst_done", wb_done, 0);
    chk("rst_cs", sram_cs, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    rst = 1'b0;
    tick();

    // 1: SEC read of 0x100, write-back at N+2
    rd(18'h100); #1;
    chk("t1_pass_cs", sram_cs, 1);
    chk("t1_pass_we", sram_we, 0);
    chk("t1_pass_addr", sram_addr, 18'h100);
    tick();
    sec(32'h1); sram_rdata = W_0001 ^ 39'h8; #1;
    chk("t1_rdata", ctrl_rdata, W_0001 ^ 39'h8);
    chk("t1_n1_cs", sram_cs, 0);
    tick();
    sram_rdata = W_0001; #1;
    chk("t1_sec", sec_count, 1);
    chk("t1_wb_cs", sram_cs, 1);
    chk("t1_wb_we", sram_we, 1);
    chk("t1_wb_addr", sram_addr, 18'h100);
    chk("t1_wb_wdata", sram_wdata, W_0001);
    chk("t1_wb_done", wb_done, 1);
    chk("t1_pending", wb_pending, 1);
    tick(); #1;
    chk("t1_done_pulse", wb_done, 0);
    chk("t1_idle_cs", sram_cs, 0);
    chk("t1_pending0", wb_pending, 0);
    rd(18'h100);
    tick(); #1;
    tick(); #1;
    chk("t1_reread_cs", sram_cs, 0);
    chk("t1_reread_sec", sec_count, 1);

    // 2: write-back held off by back-to-back functional reads
    rd(18'h104);
    tick();
    sec(32'h8000_0000);
    tick();
    for (int k = 0; k < 4; k++) begin
      rd(18'h300 + AW'(k)); #1;
      chk("t2_busy_addr", sram_addr, 18'h300 + k);
      chk("t2_busy_we", sram_we, 0);
      chk("t2_busy_done", wb_done, 0);
      tick();
    end
    #1;
    chk("t2_wb_addr", sram_addr, 18'h104);
    chk("t2_wb_we", sram_we, 1);
    chk("t2_wb_wdata", sram_wdata, W_8000);
    chk("t2_wb_done", wb_done, 1);
    chk("t2_sec", sec_count, 2);
    tick(); #1;
    chk("t2_pending0", wb_pending, 0);

    // 3: functional write to the queued address kills the write-back
    rd(18'h200);
    tick();
    sec(32'h1);
    tick();
    ctrl_cs = 1'b1; ctrl_we = 1'b1; ctrl_addr = 18'h200; ctrl_wdata = W_0010; #1;
    chk("t3_wr_addr", sram_addr, 18'h200);
    chk("t3_wr_wdata", sram_wdata, W_0010);
    chk("t3_wr_done", wb_done, 0);
    tick(); #1;
    chk("t3_pending0", wb_pending, 0);
    chk("t3_done0", wb_done, 0);
    chk("t3_cs0", sram_cs, 0);
    tick(); #1;
    chk("t3_cs0_b", sram_cs, 0);
    chk("t3_sec", sec_count, 3);

    // 4: three SEC reads while busy, queue of two, one dropped
    rd(18'h10);
    tick();
    rd(18'h20); sec(32'h1);
    tick();
    rd(18'h30); sec(32'h10);
    tick();
    rd(18'h400); sec(32'h8000_0000);
    tick(); #1;
    chk("t4_drop", wb_drop_count, 1);
    chk("t4_pending", wb_pending, 1);
    chk("t4_wb0_addr", sram_addr, 18'h10);
    chk("t4_wb0_wdata", sram_wdata, W_0001);
    chk("t4_wb0_done", wb_done, 1);
    tick(); #1;
    chk("t4_wb1_addr", sram_addr, 18'h20);
    chk("t4_wb1_wdata", sram_wdata, W_0010);
    chk("t4_wb1_done", wb_done, 1);
    tick(); #1;
    chk("t4_cs0", sram_cs, 0);
    chk("t4_pending0", wb_pending, 0);
    chk("t4_sec", sec_count, 6);

    // 5a: DED counts but never enqueues
    rd(18'h500);
    tick();
    sec(32'h1); double_ecc_error = 1'b1;
    tick(); #1;
    chk("t5_ded", ded_count, 1);
    chk("t5_sec", sec_count, 6);
    chk("t5_pending0", wb_pending, 0);
    chk("t5_cs0", sram_cs, 0);

    // 5b: two SEC reads of one address yield one write-back
    rd(18'h600);
    tick();
    rd(18'h600); sec(32'h1);
    tick();
    sec(32'h1); #1;
    chk("t5_wb_addr", sram_addr, 18'h600);
    chk("t5_wb_done", wb_done, 1);
    tick(); #1;
    chk("t5_dedup_cs", sram_cs, 0);
    chk("t5_dedup_pending", wb_pending, 0);
    chk("t5_sec2", sec_count, 8);

    // 6a: saturate sec_count with write-back disabled
    wb_en = 1'b0;
    rd(18'h700);
    tick();
    for (int k = 0; k < 16'hFFFE - 8; k++) begin
      rd(18'h700); sec(32'h1);
      tick();
    end
    #1;
    chk("t6_sec_fffe", sec_count, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      rd(18'h700); sec(32'h1);
      tick();
    end
    #1;
    chk("t6_sec_sat", sec_count, 16'hFFFF);
    chk("t6_wben_off", wb_pending, 0);
    tick();

    // 6b: reset with two entries queued
    wb_en = 1'b1;
    rd(18'h800);
    tick();
    rd(18'h900); sec(32'h1);
    tick();
    rd(18'hA00); sec(32'h1);
    tick(); #1;
    chk("t6_pending", wb_pending, 1);
    rst = 1'b1; sec(32'h1); #1;
    chk("t6_rst_cs", sram_cs, 0);
    chk("t6_rst_done", wb_done, 0);
    tick();
    rst = 1'b0; #1;
    chk("t6_post_pending", wb_pending, 0);
    chk("t6_post_sec", sec_count, 0);
    chk("t6_post_ded", ded_count, 0);
    chk("t6_post_drop", wb_drop_count, 0);
    chk("t6_post_cs", sram_cs, 0);
    tick(); #1;
    chk("t6_post_cs_b", sram_cs, 0);
    chk("t6_post_done", wb_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
